// File: rtl/key_events.sv
// key_events: debounced push-button with press / release / long-press pulses.
// The raw key is synchronized, normalized so that 1 = pressed, then tracked by
// a five-state FSM sharing one 25-bit counter for debounce and hold timing.
// All event pulses are registered, one cycle wide and mutually exclusive.
module key_events #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:1] F_KEY,
    output logic       key_state,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic [2:1] F_LED,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        HELD       = 3'd2,
        LONG       = 3'd3,
        DB_RELEASE = 3'd4
    } state_t;

    // Raw level of an untouched key, used as the synchronizer reset value.
    localparam logic        KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [24:0] DB_LAST  = 25'(DEBOUNCE_CYCLES - 1);
    localparam logic [24:0] LG_LAST  = 25'(LONG_CYCLES - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        w_k;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [24:0] r_cnt;
    logic [24:0] w_cnt_nxt;
    logic        r_long_seen;
    logic        w_long_seen_nxt;

    logic        w_press;
    logic        w_release;
    logic        w_long;

    logic        r_key_press;
    logic        r_key_release;
    logic        r_key_long;
    logic        r_led_toggle;
    logic        r_led_long;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= KEY_IDLE;
            r_sync2 <= KEY_IDLE;
        end else begin
            r_sync1 <= F_KEY[1];
            r_sync2 <= r_sync1;
        end
    end

    assign w_k = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    // FSM state, shared counter and long-press flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_long_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_long_seen <= w_long_seen_nxt;
        end
    end

    // Next-state, counter update and event decode. Every count-up path ends
    // at its compare value, so the counter can never wrap.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_long_seen_nxt = r_long_seen;
        w_press         = 1'b0;
        w_release       = 1'b0;
        w_long          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_k) begin
                    w_state_nxt = DB_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            DB_PRESS: begin
                if (!w_k) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt     = HELD;
                    w_cnt_nxt       = '0;
                    w_long_seen_nxt = 1'b0;
                    w_press         = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 25'd1;
                end
            end
            HELD: begin
                if (!w_k) begin
                    w_state_nxt = DB_RELEASE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LG_LAST) begin
                    w_state_nxt     = LONG;
                    w_cnt_nxt       = '0;
                    w_long_seen_nxt = 1'b1;
                    w_long          = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 25'd1;
                end
            end
            LONG: begin
                if (!w_k) begin
                    w_state_nxt = DB_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            DB_RELEASE: begin
                if (w_k) begin
                    // A release glitch returns to the hold state; if the long
                    // press already fired it is not fired again, otherwise the
                    // long-press timer starts over.
                    w_state_nxt = r_long_seen ? LONG : HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_release   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 25'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Registered event pulses and LED indicators.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
            r_key_long    <= 1'b0;
            r_led_toggle  <= 1'b0;
            r_led_long    <= 1'b0;
        end else begin
            r_key_press   <= w_press;
            r_key_release <= w_release;
            r_key_long    <= w_long;
            if (w_press) begin
                r_led_toggle <= ~r_led_toggle;
            end
            if (w_long) begin
                r_led_long <= 1'b1;
            end else if (w_release) begin
                r_led_long <= 1'b0;
            end
        end
    end

    assign key_press   = r_key_press;
    assign key_release = r_key_release;
    assign key_long    = r_key_long;
    assign F_LED       = {r_led_long, r_led_toggle};
    assign key_state   = (r_state == HELD) || (r_state == LONG) || (r_state == DB_RELEASE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_key_events.sv
// Testbench for key_events with DEBOUNCE_CYCLES=4, LONG_CYCLES=16, active-low key.
// Stimulus pushes expected events {kind, F_LED, edge number} into exp_q; an
// independent monitor pops and compares whenever a pulse appears.
module tb_key_events;

    localparam int DB = 4;
    localparam int LG = 16;

    localparam logic [1:0] EV_PRESS = 2'd1;
    localparam logic [1:0] EV_REL   = 2'd2;
    localparam logic [1:0] EV_LONG  = 2'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DBP  = 3'd1;
    localparam logic [2:0] S_HELD = 3'd2;
    localparam logic [2:0] S_LONG = 3'd3;
    localparam logic [2:0] S_DBR  = 3'd4;

    logic       clk;
    logic       rst;
    logic [1:1] f_key;
    logic       key_state;
    logic       key_press;
    logic       key_release;
    logic       key_long;
    logic [2:1] f_led;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int n_press  = 0;
    int n_rel    = 0;

    logic [35:0] exp_q[$];

    key_events #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .F_KEY      (f_key),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .F_LED      (f_led),
        .o_dbg_state(dbg_state)
    );

    // Clock and edge counter: at a falling edge, edge_n is the number of
    // rising edges seen so far.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [1:0] led, input int cyc);
        exp_q.push_back({kind, led, 32'(cyc)});
    endtask

    // Drive the key at a falling edge; t is the first rising edge sampling it.
    task automatic set_key(input logic lvl, output int t);
        @(negedge clk);
        f_key[1] = lvl;
        t = edge_n + 1;
    endtask

    // Advance to the falling edge following rising edge e.
    task automatic tick_to(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    // Monitor: every pulse cycle is matched against the head of exp_q.
    always @(negedge clk) begin
        logic [2:0]  pulses;
        logic [1:0]  kind;
        logic [35:0] exp_v;
        pulses = {key_press, key_release, key_long};
        if (pulses != 3'b000) begin
            kind = key_press ? EV_PRESS : (key_release ? EV_REL : EV_LONG);
            if (key_press) n_press++;
            if (key_release) n_rel++;
            if ($countones(pulses) > 1) begin
                checks++;
                failures++;
                $display("FAIL exclusive: pulses=%b expected one-hot at edge %0d", pulses, edge_n);
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: kind=%0d led=%b at edge %0d, expected none", kind, f_led, edge_n);
            end else begin
                exp_v = exp_q.pop_front();
                check("event", {kind, f_led, 32'(edge_n)}, exp_v);
            end
        end
    end

    initial begin
        int t;
        int r;
        rst      = 1'b1;
        f_key[1] = 1'b1;

        // Reset state
        tick_to(3);
        check("rst_outputs", 36'({key_state, key_press, key_release, key_long, f_led}), 36'd0);
        check("rst_state", 36'(dbg_state), 36'(S_IDLE));
        rst = 1'b0;
        tick_to(6);

        // Clean press and release
        set_key(1'b0, t);
        push_exp(EV_PRESS, 2'b01, t + 6);
        tick_to(t + 8);
        check("clean_held", 36'({key_state, f_led, dbg_state}), 36'({1'b1, 2'b01, S_HELD}));
        set_key(1'b1, r);
        push_exp(EV_REL, 2'b01, r + 6);
        tick_to(r + 10);
        check("clean_idle", 36'({key_state, f_led, dbg_state}), 36'({1'b0, 2'b01, S_IDLE}));

        // Bounce: low for three samples only
        set_key(1'b0, t);
        tick_to(t + 2);
        f_key[1] = 1'b1;
        tick_to(t + 4);
        check("bounce_db", 36'(dbg_state), 36'(S_DBP));
        tick_to(t + 8);
        check("bounce_idle", 36'({key_state, f_led, dbg_state}), 36'({1'b0, 2'b01, S_IDLE}));

        // Long press: held for 30 samples
        set_key(1'b0, t);
        push_exp(EV_PRESS, 2'b00, t + 6);
        push_exp(EV_LONG, 2'b10, t + 6 + LG);
        tick_to(t + 26);
        check("long_hold", 36'({key_state, f_led, dbg_state}), 36'({1'b1, 2'b10, S_LONG}));
        tick_to(t + 29);
        f_key[1] = 1'b1;
        push_exp(EV_REL, 2'b00, t + 36);
        tick_to(t + 40);
        check("long_idle", 36'({key_state, f_led, dbg_state}), 36'({1'b0, 2'b00, S_IDLE}));

        // Release glitch during hold restarts the long timer
        set_key(1'b0, t);
        push_exp(EV_PRESS, 2'b01, t + 6);
        tick_to(t + 9);
        f_key[1] = 1'b1;
        tick_to(t + 11);
        f_key[1] = 1'b0;
        tick_to(t + 13);
        check("glitch_dbr", 36'({key_state, dbg_state}), 36'({1'b1, S_DBR}));
        push_exp(EV_LONG, 2'b11, t + 30);
        tick_to(t + 25);
        check("glitch_restart", 36'({key_state, f_led, dbg_state}), 36'({1'b1, 2'b01, S_HELD}));
        tick_to(t + 33);
        f_key[1] = 1'b1;
        push_exp(EV_REL, 2'b01, t + 40);
        tick_to(t + 44);
        check("glitch_idle", 36'({key_state, f_led, dbg_state}), 36'({1'b0, 2'b01, S_IDLE}));

        // Reset in the middle of a press debounce, key held throughout
        set_key(1'b0, t);
        tick_to(t + 3);
        check("mid_dbp", 36'(dbg_state), 36'(S_DBP));
        rst = 1'b1;
        tick_to(t + 4);
        check("mid_rst_outputs", 36'({key_state, key_press, key_release, key_long, f_led, dbg_state}), 36'd0);
        tick_to(t + 5);
        rst = 1'b0;
        push_exp(EV_PRESS, 2'b01, t + 12);
        tick_to(t + 15);
        f_key[1] = 1'b1;
        push_exp(EV_REL, 2'b01, t + 22);
        tick_to(t + 26);

        // Second clean press toggles LED[1] back to 0
        set_key(1'b0, t);
        push_exp(EV_PRESS, 2'b00, t + 6);
        tick_to(t + 9);
        f_key[1] = 1'b1;
        push_exp(EV_REL, 2'b00, t + 16);
        tick_to(t + 20);
        check("second_idle", 36'({key_state, f_led, dbg_state}), 36'({1'b0, 2'b00, S_IDLE}));

        // End-of-run scoreboard checks
        tick_to(t + 24);
        check("exp_q_empty", 36'(exp_q.size()), 36'd0);
        check("press_count", 36'(n_press), 36'd5);
        check("release_count", 36'(n_rel), 36'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_events.md
KEY_EVENTS -- requirements
Module: key_events

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 270000, sets the stable-sample count for accepting a key transition (10 ms at 27 MHz); legal range is 2 to 2^25-1.
REQ-002 Parameter LONG_CYCLES, default 27000000, sets the count of debounced-held cycles that constitutes a long press (1 s at 27 MHz); legal range is 1 to 2^25-1.
REQ-003 Parameter KEY_ACTIVE_LOW, default 1, where 1 means F_KEY[1]=0 is pressed and 0 means F_KEY[1]=1 is pressed.
REQ-004 CLK  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 F_KEY  input  [1:1]  raw asynchronous push-button level.
REQ-007 key_state  output  1  debounced level, 1 = pressed.
REQ-008 key_press  output  1  one-cycle pulse on an accepted press.
REQ-009 key_release  output  1  one-cycle pulse on an accepted release.
REQ-010 key_long  output  1  one-cycle pulse when a press has been held for LONG_CYCLES.
REQ-011 F_LED  output  [2:1]  [1] toggles on each key_press; [2] is high from key_long until key_release.

Function
REQ-012 F_KEY[1] SHALL pass through a two-flop synchronizer, and the synchronized level SHALL be normalized to k (1 = pressed) per KEY_ACTIVE_LOW.
REQ-013 The FSM SHALL have states IDLE, DB_PRESS, HELD, LONG and DB_RELEASE, with one 25-bit counter cnt and one flag long_seen.
REQ-014 In IDLE: k=1 -> DB_PRESS with cnt=0; otherwise remain.
REQ-015 In DB_PRESS: k=0 -> IDLE with no pulse (bounce); k=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD with cnt=0, long_seen=0, key_press=1; else cnt+1.
REQ-016 In HELD: k=0 -> DB_RELEASE with cnt=0; k=1 and cnt==LONG_CYCLES-1 -> LONG with long_seen=1, key_long=1; else cnt+1.
REQ-017 In LONG: k=0 -> DB_RELEASE with cnt=0; else remain, with no further key_long.
REQ-018 In DB_RELEASE: k=1 -> LONG if long_seen, else HELD with cnt=0 (the long-press timer restarts after a release glitch); k=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE with key_release=1; else cnt+1.
REQ-019 key_state SHALL be 1 in HELD, LONG and DB_RELEASE, and 0 otherwise.
REQ-020 Latency: if edge t0 is the first edge sampling a pressed F_KEY that stays stable, key_press SHALL be high for exactly the cycle following edge t0+DEBOUNCE_CYCLES+2; release latency SHALL be identical.
REQ-021 key_press, key_release and key_long SHALL be registered, single-cycle, and mutually exclusive in any cycle.
REQ-022 key_long SHALL fire at most once per accepted press.
REQ-023 F_LED[1] SHALL toggle in the same cycle key_press is asserted.
REQ-024 F_LED[2] SHALL set with key_long and clear with key_release.
REQ-025 The counter SHALL never wrap, because every count-up path terminates at its compare value.

Reset
REQ-026 While RST=1 at a clock edge: both synchronizer flops go to the key-inactive level, state=IDLE, cnt=0, long_seen=0, and all outputs including F_LED are 0.
REQ-027 Reset mid-operation SHALL abort any debounce or hold with no pulse emitted in or after the reset cycle.
REQ-028 A key held through reset deassertion SHALL be detected as a new press after the full REQ-020 latency.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, KEY_ACTIVE_LOW=1)
REQ-029 Clean press: F_KEY 1->0 sampled at edge t0 and held -> key_press high for one cycle after edge t0+6; key_state=1; F_LED=2'b01.
REQ-030 Bounce: F_KEY low for 3 cycles then high -> no key_press; state returns to IDLE; F_LED unchanged.
REQ-031 Long press: hold low 30 cycles then release -> key_press, then key_long 16 cycles after key_press, F_LED[2]=1 until key_release; exactly one key_long.
REQ-032 Release glitch: in HELD, F_KEY high for 2 cycles then low -> no key_release; long timer restarts; key_state stays 1.
REQ-033 Reset mid-debounce: assert RST during DB_PRESS with the key still pressed, deassert -> all outputs 0; key_press arrives 6 edges after the first post-reset sample.
REQ-034 Two clean presses -> F_LED[1] sequence 0->1->0; release pulses equal press pulses in count.
